binary_output_2: RTL and testbench
==================================

Name: binary_output_2

Overview:
- Binary (XNOR-popcount) projection stage directly downstream of the 16→64 intermediate layer.
- Consumes one 64-bit binary activation vector per time step and projects it onto 16 binary weight rows, selected by block.
- Produces a 16-bit sign vector per step, through a 2-stage pipeline.
- Counts T_STEPS outputs per sequence, then raises a sticky done flag.

Parameters:
- IN_W, 64, width of the input binary vector.
- OUT_W, 16, number of output neurons (weight rows per block).
- N_BLOCKS, 4, number of weight blocks selectable by block_sel.
- T_STEPS, 30, outputs per sequence before done.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  IN_W  binary activation vector (bit 1 = +1, bit 0 = -1).
- data_in_valid  in  1  data_in is valid this cycle (no backpressure).
- block_sel  in  2  weight block used for this input; sampled with data_in_valid.
- w_wr_en  in  1  weight write strobe.
- w_wr_block  in  2  block index for the write.
- w_wr_row  in  4  row index (0..OUT_W-1) for the write.
- w_wr_data  in  IN_W  weight row data.
- clear  in  1  synchronous sequence restart.
- data_out  out  OUT_W  sign vector, bit r belongs to row r.
- data_out_valid  out  1  one-cycle pulse per produced output.
- step_idx  out  5  time-step index (0..T_STEPS-1) of the current data_out.
- done  out  1  sticky; high once T_STEPS outputs have been produced.

Behaviour:
- Reset values (async, rst_n low): data_out=0, data_out_valid=0, step_idx=0, done=0, all pipeline valids=0, weight storage=0, accept counter=0.
- Weight store: N_BLOCKS x OUT_W x IN_W flops.
  - A write lands at the clock edge.
  - A read of the same row in the same cycle returns the old data.
- Accept rule: an input is accepted when data_in_valid=1, clear=0 and acc_cnt<T_STEPS. acc_cnt increments on accept and saturates at T_STEPS. Non-accepted inputs are dropped silently.
- Stage 1 (edge after accept):
  - Per row r: x = ~(W[block_sel][r] ^ data_in).
  - Register four 5-bit chunk popcounts per row, one per 16-bit slice.
  - Register s1_valid.
- Stage 2 (next edge):
  - pc = sum of the four chunks, 7 bits, range 0..64.
  - data_out[r] = 1 iff pc > IN_W/2, i.e. signed 2*pc-IN_W > 0. A tie (pc=32) gives 0.
  - data_out_valid=1 for one cycle.
  - Latency is accept edge + 2 cycles. Throughput is one output per cycle.
- data_out holds its value between valid pulses.
- step_idx: updates with each data_out_valid to the 0-based count of that output. It holds after done.
- done: set on the same edge that presents output number T_STEPS (step_idx=T_STEPS-1). It stays high until clear or reset.
- clear:
  - Resets acc_cnt, step_idx, done and both pipeline valids. In-flight results are discarded, with no valid pulse.
  - Weights and data_out are kept.
  - If clear and data_in_valid occur in the same cycle, clear wins and the input is dropped.
- block_sel and the input are captured together, so back-to-back inputs may use different blocks.
- Reset mid-operation: all in-flight results are lost and the next sequence starts at step 0.

Decomposition:
- Shared package holds:
  - constants IN_W=64, OUT_W=16, T_STEPS=30, N_BLOCKS=4;
  - the step-index width, 5 bits;
  - the sign-threshold constant IN_W/2.
- Sub-module xnor_popcount_16: 16-bit weight slice + 16-bit activation slice in, 5-bit match count out, purely combinational. It is instantiated OUT_W x 4 times.

Test Plan:
- Block 0 all-ones weights; data_in=64'hFFFF_FFFF_FFFF_FFFF → data_out=16'hFFFF two cycles after accept; then data_in=0 → data_out=16'h0000.
- Threshold check on block 1, row 3 = 64'h0000_0000_FFFF_FFFF:
  - data_in=64'h0000_0000_FFFF_FFFF (64 matches) → bit3=1.
  - data_in=64'hFFFF_FFFF_FFFF_FFFF (32 matches, tie) → bit3=0.
  - data_in=64'h0000_0001_FFFF_FFFF (63 matches) → bit3=1.
- 31 back-to-back valid inputs:
  - outputs are the first 30 only, with step_idx 0..29 in order;
  - done rises with step_idx=29;
  - the 31st input gives no valid pulse.
- Alternate block_sel 0/1 every cycle with distinct weights → each output matches its own block; no bubbles.
- Weight write to block 2, row 5 in the same cycle an input reads block 2 → result uses the old row; the next input uses the new row.
- clear asserted one cycle after an accept, and again after done:
  - no valid pulse for the in-flight input;
  - done=0, step_idx=0;
  - the next accept yields step_idx=0.
  - Repeat the same sequence with rst_n pulsed low instead of clear, and check all outputs return to 0.

Source files
------------

// File: rtl/binary_output_2_pkg.sv
// Shared constants for the binary_output_2 XNOR-popcount projection stage.
// No ports; imported by binary_output_2 and xnor_popcount_16.
package binary_output_2_pkg;

    localparam int IN_W        = 64;   // activation / weight row width
    localparam int OUT_W       = 16;   // output neurons per block
    localparam int N_BLOCKS    = 4;    // selectable weight blocks
    localparam int T_STEPS     = 30;   // outputs per sequence
    localparam int STEP_W      = 5;    // step index / counter width
    localparam int BLK_W       = 2;
    localparam int ROW_W       = 4;
    localparam int CHUNK_W     = 16;   // popcount slice width
    localparam int N_CHUNKS    = IN_W / CHUNK_W;
    localparam int CHUNK_CNT_W = 5;    // 0..16
    localparam int PC_W        = 7;    // 0..64
    localparam int SIGN_THR    = IN_W / 2;

endpackage

// File: rtl/xnor_popcount_16.sv
// Combinational XNOR-popcount of one 16-bit slice.
// Ports:
//   w   in  16  weight slice
//   a   in  16  activation slice
//   cnt out 5   number of positions where w and a agree (0..16)
module xnor_popcount_16
    import binary_output_2_pkg::*;
(
    input  logic [CHUNK_W-1:0]     w,
    input  logic [CHUNK_W-1:0]     a,
    output logic [CHUNK_CNT_W-1:0] cnt
);

    logic [CHUNK_W-1:0] match;

    always_comb begin
        match = ~(w ^ a);
        cnt   = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            cnt = cnt + CHUNK_CNT_W'(match[i]);
        end
    end

endmodule

// File: rtl/binary_output_2.sv
// Binary projection stage: one 64-bit activation vector per step is XNOR-
// popcounted against the 16 weight rows of the selected block; each row's
// sign becomes one output bit. Two register stages (chunk counts, then sign).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   data_in, data_in_valid, block_sel  input vector, strobe, weight block
//   w_wr_en, w_wr_block, w_wr_row,
//   w_wr_data                          weight row write port
//   clear                              synchronous sequence restart
//   data_out, data_out_valid           sign vector and one-cycle strobe
//   step_idx                           0-based index of current data_out
//   done                               sticky after T_STEPS outputs
module binary_output_2
    import binary_output_2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   data_in,
    input  logic              data_in_valid,
    input  logic [BLK_W-1:0]  block_sel,
    input  logic              w_wr_en,
    input  logic [BLK_W-1:0]  w_wr_block,
    input  logic [ROW_W-1:0]  w_wr_row,
    input  logic [IN_W-1:0]   w_wr_data,
    input  logic              clear,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_out_valid,
    output logic [STEP_W-1:0] step_idx,
    output logic              done
);

    logic [IN_W-1:0]        w_mem    [N_BLOCKS][OUT_W];
    logic [CHUNK_CNT_W-1:0] chunk_cnt[OUT_W][N_CHUNKS];
    logic [CHUNK_CNT_W-1:0] s1_cnt   [OUT_W][N_CHUNKS];
    logic                   s1_valid;
    logic [PC_W-1:0]        pc       [OUT_W];
    logic [OUT_W-1:0]       sign;
    logic [STEP_W-1:0]      acc_cnt;
    logic [STEP_W-1:0]      out_cnt;
    logic                   accept;

    assign accept = data_in_valid && !clear && (acc_cnt < STEP_W'(T_STEPS));

    // Weight store; a same-cycle read of the written row sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < N_BLOCKS; b++) begin
                for (int r = 0; r < OUT_W; r++) begin
                    w_mem[b][r] <= '0;
                end
            end
        end else if (w_wr_en) begin
            w_mem[w_wr_block][w_wr_row] <= w_wr_data;
        end
    end

    for (genvar r = 0; r < OUT_W; r++) begin : g_row
        for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
            xnor_popcount_16 u_pc (
                .w   (w_mem[block_sel][r][c*CHUNK_W +: CHUNK_W]),
                .a   (data_in[c*CHUNK_W +: CHUNK_W]),
                .cnt (chunk_cnt[r][c])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            s1_valid <= 1'b0;
            for (int r = 0; r < OUT_W; r++) begin
                for (int c = 0; c < N_CHUNKS; c++) begin
                    s1_cnt[r][c] <= '0;
                end
            end
        end else begin
            s1_valid <= accept;
            if (clear) begin
                acc_cnt <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (accept) begin
                s1_cnt <= chunk_cnt;
            end
        end
    end

    // A tie (pc == IN_W/2) is treated as negative.
    always_comb begin
        sign = '0;
        for (int r = 0; r < OUT_W; r++) begin
            pc[r] = '0;
            for (int c = 0; c < N_CHUNKS; c++) begin
                pc[r] = pc[r] + PC_W'(s1_cnt[r][c]);
            end
            sign[r] = pc[r] > PC_W'(SIGN_THR);
        end
    end

    // out_cnt is the index the next produced output will carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            step_idx       <= '0;
            done           <= 1'b0;
            out_cnt        <= '0;
        end else if (clear) begin
            data_out_valid <= 1'b0;
            step_idx       <= '0;
            done           <= 1'b0;
            out_cnt        <= '0;
        end else begin
            data_out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= sign;
                step_idx <= out_cnt;
                out_cnt  <= out_cnt + 1'b1;
                if (out_cnt == STEP_W'(T_STEPS - 1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_output_2.sv
module tb_binary_output_2;

    localparam int NSTEP = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic [1:0]  block_sel;
    logic        w_wr_en;
    logic [1:0]  w_wr_block;
    logic [3:0]  w_wr_row;
    logic [63:0] w_wr_data;
    logic        clear;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [4:0]  step_idx;
    logic        done;

    binary_output_2 dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .block_sel(block_sel), .w_wr_en(w_wr_en), .w_wr_block(w_wr_block),
        .w_wr_row(w_wr_row), .w_wr_data(w_wr_data), .clear(clear),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_pulses = 0;

    // reference model state
    typedef struct { int due; logic [15:0] val; } pend_t;
    pend_t       pend[$];
    logic [63:0] mw [4][16];
    int          m_acc, m_outcnt, cyc;
    logic [15:0] e_out;
    logic        e_valid, e_done;
    logic [4:0]  e_step;

    typedef struct { logic [1:0] blk; logic [63:0] din; logic [15:0] exp_out; } vec_t;
    vec_t vt[5];

    function automatic logic [15:0] ref_out(input logic [1:0] b, input logic [63:0] d);
        logic [15:0] o;
        for (int r = 0; r < 16; r++) o[r] = ($countones(~(mw[b][r] ^ d)) > 32);
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_all();
        chk("valid", 64'(data_out_valid), 64'(e_valid));
        chk("data_out", 64'(data_out), 64'(e_out));
        chk("step_idx", 64'(step_idx), 64'(e_step));
        chk("done", 64'(done), 64'(e_done));
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) for (int r = 0; r < 16; r++) mw[b][r] = '0;
        pend.delete();
        m_acc = 0; m_outcnt = 0;
        e_out = '0; e_valid = 0; e_done = 0; e_step = '0;
    endtask

    task automatic idle_inputs();
        data_in_valid = 0; data_in = '0; block_sel = '0; clear = 0;
        w_wr_en = 0; w_wr_block = '0; w_wr_row = '0; w_wr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (clear) begin
            pend.delete();
            m_acc = 0; m_outcnt = 0;
            e_valid = 0; e_step = '0; e_done = 0;
        end else begin
            e_valid = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e_out = pend[0].val;
                void'(pend.pop_front());
                e_valid = 1;
                e_step = 5'(m_outcnt);
                m_outcnt++;
                if (m_outcnt == NSTEP) e_done = 1;
            end
            if (data_in_valid && m_acc < NSTEP) begin
                pend.push_back('{cyc + 1, ref_out(block_sel, data_in)});
                m_acc++;
            end
        end
        if (w_wr_en) mw[w_wr_block][w_wr_row] = w_wr_data;
        cyc++;
        #1;
        chk_all();
        if (data_out_valid) n_pulses++;
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] r, input logic [63:0] d);
        w_wr_en = 1; w_wr_block = b; w_wr_row = r; w_wr_data = d;
        tick();
        w_wr_en = 0;
    endtask

    task automatic send(input logic [1:0] b, input logic [63:0] d);
        data_in_valid = 1; block_sel = b; data_in = d;
        tick();
        data_in_valid = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        chk_all();
        chk("rst data_out zero", 64'(data_out), 64'h0);
        rst_n = 1;
    endtask

    initial begin
        int p0;
        idle_inputs();
        cyc = 0;
        rst_n = 0;
        #3;
        model_reset();
        chk_all();
        @(posedge clk); #1;
        rst_n = 1;

        // Block 0 all-ones, block 1 row 3 threshold row; other rows stay zero.
        for (int r = 0; r < 16; r++) wr(2'd0, 4'(r), 64'hFFFF_FFFF_FFFF_FFFF);
        wr(2'd1, 4'd3, 64'h0000_0000_FFFF_FFFF);

        vt[0] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF};
        vt[1] = '{2'd0, 64'h0,                   16'h0000};
        vt[2] = '{2'd1, 64'h0000_0000_FFFF_FFFF, 16'h0008};
        vt[3] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000};
        vt[4] = '{2'd1, 64'h0000_0001_FFFF_FFFF, 16'h0008};
        for (int i = 0; i < 5; i++) begin
            send(vt[i].blk, vt[i].din);
            tick();
            chk("table data_out", 64'(data_out), 64'(vt[i].exp_out));
            chk("table valid", 64'(data_out_valid), 64'h1);
        end

        // 31 back-to-back inputs with random weights and blocks.
        do_clear();
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) wr(2'(b), 4'(r), {$urandom, $urandom});
        p0 = n_pulses;
        for (int i = 0; i < 31; i++) begin
            data_in_valid = 1; block_sel = 2'($urandom_range(0, 3)); data_in = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
        chk("31 inputs pulse count", 64'(n_pulses - p0), 64'd30);
        chk("31 inputs done", 64'(done), 64'h1);
        chk("31 inputs last step", 64'(step_idx), 64'd29);

        // Alternating blocks 0/1, no bubbles expected.
        do_clear();
        p0 = n_pulses;
        for (int i = 0; i < 10; i++) begin
            data_in_valid = 1; block_sel = 2'(i % 2); data_in = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        tick();
        chk("alternate pulse count", 64'(n_pulses - p0), 64'd10);

        // Write/read collision on block 2 row 5.
        do_clear();
        wr(2'd2, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        data_in_valid = 1; block_sel = 2'd2; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        w_wr_en = 1; w_wr_block = 2'd2; w_wr_row = 4'd5; w_wr_data = 64'h0;
        tick();
        w_wr_en = 0;
        tick();
        chk("collision old row bit5", 64'(data_out[5]), 64'h1);
        idle_inputs();
        tick();
        chk("collision new row bit5", 64'(data_out[5]), 64'h0);

        // clear one cycle after an accept
        do_clear();
        send(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_clear();
        tick();
        chk("clear inflight no pulse", 64'(data_out_valid), 64'h0);
        chk("clear step", 64'(step_idx), 64'h0);
        send(2'd0, 64'h0);
        tick();
        chk("after clear first step", 64'(step_idx), 64'h0);
        chk("after clear first valid", 64'(data_out_valid), 64'h1);
        // run to done, then clear
        do_clear();
        for (int i = 0; i < NSTEP; i++) send(2'(i % 4), {$urandom, $urandom});
        tick(); tick();
        chk("run done", 64'(done), 64'h1);
        do_clear();
        chk("clear after done", 64'(done), 64'h0);
        chk("clear after done step", 64'(step_idx), 64'h0);

        // same, with reset instead of clear
        send(2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_reset();
        tick();
        chk("reset inflight no pulse", 64'(data_out_valid), 64'h0);
        send(2'd0, 64'h0);
        tick();
        chk("after reset first step", 64'(step_idx), 64'h0);
        for (int i = 0; i < NSTEP; i++) send(2'd1, {$urandom, $urandom});
        tick();
        do_reset();
        chk("reset done", 64'(done), 64'h0);
        chk("reset step", 64'(step_idx), 64'h0);
        chk("reset data_out", 64'(data_out), 64'h0);
        tick();

        // randomized mix against the model
        for (int i = 0; i < 400; i++) begin
            data_in_valid = ($urandom_range(0, 3) != 0);
            block_sel     = 2'($urandom_range(0, 3));
            data_in       = {$urandom, $urandom};
            clear         = ($urandom_range(0, 24) == 0);
            w_wr_en       = ($urandom_range(0, 7) == 0);
            w_wr_block    = 2'($urandom_range(0, 3));
            w_wr_row      = 4'($urandom_range(0, 15));
            w_wr_data     = {$urandom, $urandom};
            tick();
        end
        idle_inputs();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
